// File: rtl/axis_frame_gen_pkg.sv
// Shared definitions for the AXI4-Stream frame generator: FSM encoding and
// the width of the completed-frame counter.
package axis_frame_gen_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  localparam int FRAME_COUNT_W = 16;

endpackage

// File: rtl/axis_frame_gen.sv
// Command-driven AXI4-Stream frame transmitter: one descriptor in, one frame of
// incrementing byte pattern out, with tkeep trimmed and tlast on the final beat.
module axis_frame_gen
  import axis_frame_gen_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int LEN_WIDTH   = 16,
  parameter int ID_ENABLE   = 0,
  parameter int ID_WIDTH    = 8,
  parameter int DEST_ENABLE = 0,
  parameter int DEST_WIDTH  = 8,
  parameter int USER_WIDTH  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [LEN_WIDTH-1:0]     cmd_len,
  input  logic [7:0]               cmd_seed,
  input  logic [ID_WIDTH-1:0]      cmd_id,
  input  logic [DEST_WIDTH-1:0]    cmd_dest,
  input  logic [USER_WIDTH-1:0]    cmd_user,
  output logic [DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]    m_axis_tkeep,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic [ID_WIDTH-1:0]      m_axis_tid,
  output logic [DEST_WIDTH-1:0]    m_axis_tdest,
  output logic [USER_WIDTH-1:0]    m_axis_tuser,
  output logic                     busy,
  output logic [FRAME_COUNT_W-1:0] frame_count,
  output logic                     zero_len
);

  localparam logic [LEN_WIDTH-1:0] KEEP_LEN  = LEN_WIDTH'(KEEP_WIDTH);
  localparam logic [7:0]           KEEP_BYTE = 8'(KEEP_WIDTH);

  // Lane j carries base + j while fewer than 'bytes' lanes are used; unused lanes are 0.
  function automatic logic [DATA_WIDTH-1:0] beat_data(input logic [7:0]           base,
                                                      input logic [LEN_WIDTH-1:0] bytes);
    logic [DATA_WIDTH-1:0] d;
    d = '0;
    for (int j = 0; j < KEEP_WIDTH; j++) begin
      if (LEN_WIDTH'(j) < bytes) d[8*j +: 8] = base + 8'(j);
    end
    return d;
  endfunction

  function automatic logic [KEEP_WIDTH-1:0] beat_keep(input logic [LEN_WIDTH-1:0] bytes);
    logic [KEEP_WIDTH-1:0] k;
    k = '0;
    for (int j = 0; j < KEEP_WIDTH; j++) begin
      if (LEN_WIDTH'(j) < bytes) k[j] = 1'b1;
    end
    return k;
  endfunction

  state_t                   state_q, state_d;
  logic                     cmd_ready_q, cmd_ready_d;
  logic                     tvalid_q, tvalid_d;
  logic [DATA_WIDTH-1:0]    tdata_q, tdata_d;
  logic [KEEP_WIDTH-1:0]    tkeep_q, tkeep_d;
  logic                     tlast_q, tlast_d;
  logic [ID_WIDTH-1:0]      tid_q, tid_d;
  logic [DEST_WIDTH-1:0]    tdest_q, tdest_d;
  logic [USER_WIDTH-1:0]    tuser_q, tuser_d;
  logic                     busy_q, busy_d;
  logic [FRAME_COUNT_W-1:0] frame_count_q, frame_count_d;
  logic                     zero_len_q, zero_len_d;

  // Datapath state: bytes still to be presented after the current beat, and
  // the byte value of lane 0 of the next beat.
  logic [LEN_WIDTH-1:0]     rem_q, rem_d;
  logic [7:0]               base_q, base_d;
  logic [USER_WIDTH-1:0]    user_q, user_d;

  logic                     last_beat;

  always_comb begin
    state_d       = state_q;
    cmd_ready_d   = cmd_ready_q;
    tvalid_d      = tvalid_q;
    tdata_d       = tdata_q;
    tkeep_d       = tkeep_q;
    tlast_d       = tlast_q;
    tid_d         = tid_q;
    tdest_d       = tdest_q;
    tuser_d       = tuser_q;
    busy_d        = busy_q;
    frame_count_d = frame_count_q;
    zero_len_d    = 1'b0;
    rem_d         = rem_q;
    base_d        = base_q;
    user_d        = user_q;
    last_beat     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          if (cmd_len == '0) begin
            zero_len_d = 1'b1;
          end else begin
            last_beat   = (cmd_len <= KEEP_LEN);
            state_d     = ST_SEND;
            cmd_ready_d = 1'b0;
            busy_d      = 1'b1;
            tvalid_d    = 1'b1;
            tdata_d     = beat_data(cmd_seed, cmd_len);
            tkeep_d     = beat_keep(cmd_len);
            tlast_d     = last_beat;
            tid_d       = cmd_id & {ID_WIDTH{ID_ENABLE != 0}};
            tdest_d     = cmd_dest & {DEST_WIDTH{DEST_ENABLE != 0}};
            tuser_d     = last_beat ? cmd_user : '0;
            user_d      = cmd_user;
            rem_d       = last_beat ? '0 : cmd_len - KEEP_LEN;
            base_d      = cmd_seed + KEEP_BYTE;
          end
        end
      end

      ST_SEND: begin
        if (m_axis_tready) begin
          if (tlast_q) begin
            state_d       = ST_IDLE;
            cmd_ready_d   = 1'b1;
            busy_d        = 1'b0;
            tvalid_d      = 1'b0;
            tdata_d       = '0;
            tkeep_d       = '0;
            tlast_d       = 1'b0;
            tid_d         = '0;
            tdest_d       = '0;
            tuser_d       = '0;
            frame_count_d = frame_count_q + 1'b1;
          end else begin
            last_beat = (rem_q <= KEEP_LEN);
            tdata_d   = beat_data(base_q, rem_q);
            tkeep_d   = beat_keep(rem_q);
            tlast_d   = last_beat;
            tuser_d   = last_beat ? user_q : '0;
            rem_d     = last_beat ? '0 : rem_q - KEEP_LEN;
            base_d    = base_q + KEEP_BYTE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Control and all visible outputs: cleared on reset, which also abandons any
  // frame in flight without tlast or a count increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cmd_ready_q   <= 1'b0;
      tvalid_q      <= 1'b0;
      tdata_q       <= '0;
      tkeep_q       <= '0;
      tlast_q       <= 1'b0;
      tid_q         <= '0;
      tdest_q       <= '0;
      tuser_q       <= '0;
      busy_q        <= 1'b0;
      frame_count_q <= '0;
      zero_len_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      tvalid_q      <= tvalid_d;
      tdata_q       <= tdata_d;
      tkeep_q       <= tkeep_d;
      tlast_q       <= tlast_d;
      tid_q         <= tid_d;
      tdest_q       <= tdest_d;
      tuser_q       <= tuser_d;
      busy_q        <= busy_d;
      frame_count_q <= frame_count_d;
      zero_len_q    <= zero_len_d;
    end
  end

  // Pattern bookkeeping is only meaningful in SEND and is reloaded on every accept.
  always_ff @(posedge clk) begin
    rem_q  <= rem_d;
    base_q <= base_d;
    user_q <= user_d;
  end

  assign cmd_ready     = cmd_ready_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tid    = tid_q;
  assign m_axis_tdest  = tdest_q;
  assign m_axis_tuser  = tuser_q;
  assign busy          = busy_q;
  assign frame_count   = frame_count_q;
  assign zero_len      = zero_len_q;

endmodule
